mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 110 +++++++++++
 rtl/mc_decode.sv | 93 +++++++++
 rtl/mc_control.sv | 170 +++++++++++++++++
 tb/tb_mc_control.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// instruction classes, ALU codes, opcodes and datapath select encodings.
package mc_pkg;

  // Controller states; the value is also exported on the debug port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Instruction classes as seen by the sequencer.
  typedef enum logic [3:0] {
    CL_NOP    = 4'd0,
    CL_ALU    = 4'd1,
    CL_LUI    = 4'd2,
    CL_AUIPC  = 4'd3,
    CL_JAL    = 4'd4,
    CL_JALR   = 4'd5,
    CL_BRANCH = 4'd6,
    CL_LOAD   = 4'd7,
    CL_STORE  = 4'd8
  } iclass_e;

  // ALU operation codes.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Immediate formats.
  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_S = 3'd1;
  localparam logic [2:0] EXT_B = 3'd2;
  localparam logic [2:0] EXT_U = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;

  // ALU operand B sources.
  localparam logic [1:0] BSRC_RS2  = 2'd0;
  localparam logic [1:0] BSRC_IMM  = 2'd1;
  localparam logic [1:0] BSRC_FOUR = 2'd2;

  // Write-back sources.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Next-PC sources.
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  // ALU code for OP / OP-IMM; funct7[5] selects SUB only for register forms,
  // while it selects SRA for both shift forms.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                             input logic       f7b5,
                                             input logic       is_reg);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  // Branch resolution from the compare flags of the ALU.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       less,
                                        input logic       zero);
    logic t;
    case (f3)
      3'b000:         t = zero;
      3'b001:         t = ~zero;
      3'b100, 3'b110: t = less;
      3'b101, 3'b111: t = ~less;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR -> ALU controls, immediate format,
// instruction class and illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [3:0]  alu_ctr_o,
  output logic        alu_asrc_o,
  output logic [1:0]  alu_bsrc_o,
  output logic [2:0]  ext_op_o,
  output iclass_e     iclass_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_ir_bits;

  assign opcode = ir_i[6:0];
  assign funct3 = ir_i[14:12];
  assign f7b5   = ir_i[30];
  // Register and immediate fields belong to the datapath, not to control.
  assign unused_ir_bits = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

  // Decode opcode/funct fields into control fields and legality.
  always_comb begin
    alu_ctr_o  = ALU_ADD;
    alu_asrc_o = 1'b0;
    alu_bsrc_o = BSRC_RS2;
    ext_op_o   = EXT_I;
    iclass_o   = CL_NOP;
    illegal_o  = 1'b0;
    case (opcode)
      OPC_OP: begin
        iclass_o  = CL_ALU;
        alu_ctr_o = alu_from_f3(funct3, f7b5, 1'b1);
      end
      OPC_OP_IMM: begin
        iclass_o   = CL_ALU;
        alu_bsrc_o = BSRC_IMM;
        alu_ctr_o  = alu_from_f3(funct3, f7b5, 1'b0);
      end
      OPC_LUI: begin
        iclass_o   = CL_LUI;
        alu_ctr_o  = ALU_LUI;
        alu_bsrc_o = BSRC_IMM;
        ext_op_o   = EXT_U;
      end
      OPC_AUIPC: begin
        iclass_o   = CL_AUIPC;
        alu_asrc_o = 1'b1;
        alu_bsrc_o = BSRC_IMM;
        ext_op_o   = EXT_U;
      end
      OPC_JAL: begin
        iclass_o   = CL_JAL;
        alu_asrc_o = 1'b1;
        alu_bsrc_o = BSRC_IMM;
        ext_op_o   = EXT_J;
      end
      OPC_JALR: begin
        iclass_o   = CL_JALR;
        alu_bsrc_o = BSRC_IMM;
      end
      OPC_BRANCH: begin
        iclass_o  = CL_BRANCH;
        ext_op_o  = EXT_B;
        // funct3[1] separates the unsigned compares from the signed ones.
        alu_ctr_o = funct3[1] ? ALU_SLTU : ALU_SLT;
        illegal_o = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        iclass_o   = CL_LOAD;
        alu_bsrc_o = BSRC_IMM;
        illegal_o  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        iclass_o   = CL_STORE;
        alu_bsrc_o = BSRC_IMM;
        ext_op_o   = EXT_S;
        illegal_o  = (funct3 > 3'b010);
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        iclass_o = CL_NOP;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// TRAP state for illegal instructions.
//
// Handshakes: imem_req and dmem_req are levels raised by the controller and
// held until the matching ack is seen high on a rising edge; the ack cycle
// completes the transfer, and an ack outside its owning state is ignored.
module mc_control
  import mc_pkg::*;
#(
  parameter int TRAP_HALT = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic        ir_we,
  output logic [2:0]  ext_op,
  output logic [3:0]  alu_ctr,
  output logic        alu_asrc,
  output logic [1:0]  alu_bsrc,
  input  logic        alu_less,
  input  logic        alu_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic [2:0]  dbg_state_o
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [3:0]  dec_alu_ctr;
  logic        dec_asrc;
  logic [1:0]  dec_bsrc;
  logic [2:0]  dec_ext_op;
  iclass_e     dec_class;
  logic        dec_illegal;
  logic        dec_active;
  logic        taken;

  // Decode always works on the controller's private IR copy.
  mc_decode u_decode (
    .ir_i       (ir_q),
    .alu_ctr_o  (dec_alu_ctr),
    .alu_asrc_o (dec_asrc),
    .alu_bsrc_o (dec_bsrc),
    .ext_op_o   (dec_ext_op),
    .iclass_o   (dec_class),
    .illegal_o  (dec_illegal)
  );

  assign taken       = branch_taken(ir_q[14:12], alu_less, alu_zero);
  assign dbg_state_o = state_q;

  // Next state and IR capture.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        if (dec_class == CL_BRANCH) begin
          state_d = ST_FETCH;
        end else if ((dec_class == CL_LOAD) || (dec_class == CL_STORE)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = (dec_class == CL_LOAD) ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: state_d = ST_FETCH;
      ST_TRAP: begin
        if (TRAP_HALT == 0) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Decoder fields are only meaningful once IR holds the current instruction.
  assign dec_active = !rst && ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                               (state_q == ST_MEM)    || (state_q == ST_WB));

  // Moore/Mealy control outputs; everything is forced low while rst is high.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    halted   = 1'b0;
    ext_op   = dec_active ? dec_ext_op  : EXT_I;
    alu_ctr  = dec_active ? dec_alu_ctr : ALU_ADD;
    alu_asrc = dec_active ? dec_asrc    : 1'b0;
    alu_bsrc = dec_active ? dec_bsrc    : BSRC_RS2;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        ST_EXEC: begin
          if (dec_class == CL_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = taken ? PC_REL : PC_PLUS4;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (dec_class == CL_STORE);
          // A store retires in its ack cycle; a load still needs WB.
          pc_we    = (dec_class == CL_STORE) && dmem_ack;
        end
        ST_WB: begin
          pc_we = 1'b1;
          rf_we = (dec_class != CL_NOP);
          case (dec_class)
            CL_JAL: begin
              pc_sel = PC_REL;
              wb_sel = WB_PC4;
            end
            CL_JALR: begin
              pc_sel = PC_JALR;
              wb_sel = WB_PC4;
            end
            CL_LOAD: wb_sel = WB_MEM;
            default: wb_sel = WB_ALU;
          endcase
        end
        ST_TRAP: begin
          halted = 1'b1;
          pc_we  = (TRAP_HALT == 0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control. Two instances share all inputs: dut uses
// TRAP_HALT=1, dut_nh uses TRAP_HALT=0.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack, dmem_ack, alu_less, alu_zero;
  logic [31:0] instr;

  logic        imem_req, ir_we, alu_asrc, dmem_req, dmem_we, rf_we, pc_we, halted;
  logic [2:0]  ext_op, dbg_state;
  logic [3:0]  alu_ctr;
  logic [1:0]  alu_bsrc, wb_sel, pc_sel;

  logic        imem_req_n, ir_we_n, alu_asrc_n, dmem_req_n, dmem_we_n, rf_we_n, pc_we_n, halted_n;
  logic [2:0]  ext_op_n, dbg_state_n;
  logic [3:0]  alu_ctr_n;
  logic [1:0]  alu_bsrc_n, wb_sel_n, pc_sel_n;

  int n_chk  = 0;
  int n_pass = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  mc_control #(.TRAP_HALT(1)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .ir_we(ir_we), .ext_op(ext_op), .alu_ctr(alu_ctr), .alu_asrc(alu_asrc),
    .alu_bsrc(alu_bsrc), .alu_less(alu_less), .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted),
    .dbg_state_o(dbg_state)
  );

  mc_control #(.TRAP_HALT(0)) dut_nh (
    .clk(clk), .rst(rst), .imem_req(imem_req_n), .imem_ack(imem_ack), .instr(instr),
    .ir_we(ir_we_n), .ext_op(ext_op_n), .alu_ctr(alu_ctr_n), .alu_asrc(alu_asrc_n),
    .alu_bsrc(alu_bsrc_n), .alu_less(alu_less), .alu_zero(alu_zero),
    .dmem_req(dmem_req_n), .dmem_we(dmem_we_n), .dmem_ack(dmem_ack), .rf_we(rf_we_n),
    .wb_sel(wb_sel_n), .pc_we(pc_we_n), .pc_sel(pc_sel_n), .halted(halted_n),
    .dbg_state_o(dbg_state_n)
  );

  // ---------------- driver tasks ----------------
  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles; returns in the first cycle after release (FETCH).
  task automatic apply_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    instr = '0; alu_less = 1'b0; alu_zero = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Complete a zero-wait fetch; returns in DECODE with instr poisoned so any
  // use of the raw bus instead of IR shows up.
  task automatic fetch_instr(input logic [31:0] w);
    instr = w;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    instr = 32'hFFFF_FFFF;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    instr = '0; alu_less = 1'b0; alu_zero = 1'b0;
    step();
    step();
    n_chk++;
    if ({imem_req, ir_we, rf_we, pc_we, dmem_req, halted, dbg_state} !== 9'b0)
      $display("FAIL reset_outputs: got %b want %b",
               {imem_req, ir_we, rf_we, pc_we, dmem_req, halted, dbg_state}, 9'b0);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({imem_req, dmem_req, halted} !== 3'b100)
      $display("FAIL reset_release_fetch: got %b want %b", {imem_req, dmem_req, halted}, 3'b100);
    else n_pass++;
    // Reset while a fetch is outstanding drops the request.
    rst = 1'b1;
    step();
    n_chk++;
    if (imem_req !== 1'b0) $display("FAIL reset_mid_fetch: got %b want 0", imem_req);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b1) $display("FAIL reset_mid_fetch_release: got %b want 1", imem_req);
    else n_pass++;
  endtask

  task automatic test_add();
    apply_reset();
    instr = 32'h0020_81B3;  // add x3,x1,x2
    imem_ack = 1'b1;
    #1;
    n_chk++;
    if ({imem_req, ir_we} !== 2'b11) $display("FAIL add_c1_fetch: got %b want 11", {imem_req, ir_we});
    else n_pass++;
    step();
    // DECODE: a stray ack with an illegal word must be ignored.
    instr = 32'h0000_007F;
    #1;
    n_chk++;
    if ({ir_we, imem_req, rf_we, pc_we} !== 4'b0000)
      $display("FAIL add_c2_decode: got %b want 0000", {ir_we, imem_req, rf_we, pc_we});
    else n_pass++;
    step();
    imem_ack = 1'b0;
    #1;
    n_chk++;
    if ({alu_ctr, alu_asrc, alu_bsrc, rf_we, pc_we, halted} !== 10'b0000_0_00_000)
      $display("FAIL add_c3_exec: got %b want %b", {alu_ctr, alu_asrc, alu_bsrc, rf_we, pc_we, halted}, 10'b0);
    else n_pass++;
    step();
    #1;
    n_chk++;
    if ({rf_we, pc_we, pc_sel, wb_sel, alu_ctr} !== 10'b1_1_00_00_0000)
      $display("FAIL add_c4_wb: got %b want %b", {rf_we, pc_we, pc_sel, wb_sel, alu_ctr}, 10'b1100000000);
    else n_pass++;
    step();
    #1;
    n_chk++;
    if ({imem_req, rf_we, pc_we} !== 3'b100)
      $display("FAIL add_c5_refetch: got %b want 100", {imem_req, rf_we, pc_we});
    else n_pass++;
  endtask

  // ALU-class instructions issued back to back: {alu_ctr, asrc, bsrc, ext_op, rf_we}.
  task automatic test_alu_ops();
    logic [31:0] w [12] = '{32'h0050_0093, 32'h0010_B113, 32'h0020_C1B3, 32'h4020_D1B3,
                            32'h4030_D113, 32'h1234_52B7, 32'h0000_1297, 32'h0020_F1B3,
                            32'h0020_91B3, 32'h4020_81B3, 32'h0000_000F, 32'h0000_0073};
    logic [10:0] e [12] = '{11'b0000_0_01_000_1, 11'b1010_0_01_000_1, 11'b0100_0_00_000_1,
                            11'b1101_0_00_000_1, 11'b1101_0_01_000_1, 11'b0011_0_01_011_1,
                            11'b0000_1_01_011_1, 11'b0111_0_00_000_1, 11'b0001_0_00_000_1,
                            11'b1000_0_00_000_1, 11'b0000_0_00_000_0, 11'b0000_0_00_000_0};
    logic [10:0] exp_e;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      exp_e = e[i];
      #1;
      n_chk++;
      if (imem_req !== 1'b1) $display("FAIL alu_fetch[%0d]: got %b want 1", i, imem_req);
      else n_pass++;
      fetch_instr(w[i]);
      step();
      #1;
      n_chk++;
      if ({alu_ctr, alu_asrc, alu_bsrc, ext_op} !== exp_e[10:1])
        $display("FAIL alu_exec[%0d]: got %b want %b", i, {alu_ctr, alu_asrc, alu_bsrc, ext_op}, exp_e[10:1]);
      else n_pass++;
      step();
      #1;
      n_chk++;
      if ({rf_we, pc_we, pc_sel, wb_sel} !== {exp_e[0], 1'b1, 2'b00, 2'b00})
        $display("FAIL alu_wb[%0d]: got %b want %b", i, {rf_we, pc_we, pc_sel, wb_sel}, {exp_e[0], 5'b10000});
      else n_pass++;
      step();
    end
  endtask

  // Branches: {less, zero, exp_alu_ctr, exp_pc_sel}.
  task automatic test_branch();
    logic [31:0] w [6] = '{32'h0020_E463, 32'h0020_E463, 32'h0020_8463,
                           32'h0020_9463, 32'h0020_D463, 32'h0020_F463};
    logic [7:0]  v [6] = '{8'b1_0_1010_01, 8'b0_0_1010_00, 8'b0_1_0010_01,
                           8'b0_1_0010_00, 8'b0_0_0010_01, 8'b1_0_1010_00};
    logic [7:0]  cur;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cur = v[i];
      fetch_instr(w[i]);
      step();
      alu_less = cur[7];
      alu_zero = cur[6];
      #1;
      n_chk++;
      if ({alu_ctr, ext_op, pc_we, pc_sel, rf_we} !== {cur[5:2], 3'd2, 1'b1, cur[1:0], 1'b0})
        $display("FAIL branch_exec[%0d]: got %b want %b", i, {alu_ctr, ext_op, pc_we, pc_sel, rf_we},
                 {cur[5:2], 3'd2, 1'b1, cur[1:0], 1'b0});
      else n_pass++;
      step();
      alu_less = 1'b0;
      alu_zero = 1'b0;
      #1;
      n_chk++;
      if ({imem_req, rf_we, pc_we} !== 3'b100)
        $display("FAIL branch_refetch[%0d]: got %b want 100", i, {imem_req, rf_we, pc_we});
      else n_pass++;
    end
  endtask

  task automatic test_load_delayed();
    apply_reset();
    fetch_instr(32'h0040_A183);  // lw x3,4(x1)
    step();
    #1;
    n_chk++;
    if ({dmem_req, alu_ctr, alu_bsrc, ext_op} !== 10'b0_0000_01_000)
      $display("FAIL load_exec: got %b want %b", {dmem_req, alu_ctr, alu_bsrc, ext_op}, 10'b0000001000);
    else n_pass++;
    step();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      n_chk++;
      if ({dmem_req, dmem_we, rf_we, pc_we} !== 4'b1000)
        $display("FAIL load_mem[%0d]: got %b want 1000", i, {dmem_req, dmem_we, rf_we, pc_we});
      else n_pass++;
      step();
    end
    dmem_ack = 1'b0;
    #1;
    n_chk++;
    if ({rf_we, pc_we, wb_sel, pc_sel, dmem_req} !== 7'b1_1_01_00_0)
      $display("FAIL load_wb: got %b want %b", {rf_we, pc_we, wb_sel, pc_sel, dmem_req}, 7'b1101000);
    else n_pass++;
    step();
    #1;
    n_chk++;
    if (imem_req !== 1'b1) $display("FAIL load_refetch: got %b want 1", imem_req);
    else n_pass++;
  endtask

  task automatic test_store();
    apply_reset();
    fetch_instr(32'h0020_A423);  // sw x2,8(x1)
    step();
    step();
    dmem_ack = 1'b1;
    #1;
    n_chk++;
    if ({dmem_req, dmem_we, pc_we, pc_sel, rf_we, ext_op} !== 9'b1_1_1_00_0_001)
      $display("FAIL store_mem: got %b want %b", {dmem_req, dmem_we, pc_we, pc_sel, rf_we, ext_op}, 9'b111000001);
    else n_pass++;
    step();
    dmem_ack = 1'b0;
    #1;
    n_chk++;
    if ({imem_req, dmem_req, rf_we} !== 3'b100)
      $display("FAIL store_refetch: got %b want 100", {imem_req, dmem_req, rf_we});
    else n_pass++;
  endtask

  task automatic test_jumps();
    apply_reset();
    fetch_instr(32'h0002_80E7);  // jalr x1,0(x5)
    step();
    #1;
    n_chk++;
    if ({alu_ctr, alu_asrc, alu_bsrc, ext_op} !== 10'b0000_0_01_000)
      $display("FAIL jalr_exec: got %b want %b", {alu_ctr, alu_asrc, alu_bsrc, ext_op}, 10'b0000001000);
    else n_pass++;
    step();
    #1;
    n_chk++;
    if ({rf_we, pc_we, wb_sel, pc_sel} !== 6'b1_1_10_10)
      $display("FAIL jalr_wb: got %b want 111010", {rf_we, pc_we, wb_sel, pc_sel});
    else n_pass++;
    step();
    fetch_instr(32'h0000_00EF);  // jal x1,0
    step();
    step();
    #1;
    n_chk++;
    if ({rf_we, pc_we, wb_sel, pc_sel, ext_op} !== 9'b1_1_10_01_100)
      $display("FAIL jal_wb: got %b want 111001100", {rf_we, pc_we, wb_sel, pc_sel, ext_op});
    else n_pass++;
    step();
  endtask

  task automatic test_trap();
    apply_reset();
    fetch_instr(32'h0000_007F);
    #1;
    n_chk++;
    if ({halted, halted_n} !== 2'b00) $display("FAIL trap_decode: got %b want 00", {halted, halted_n});
    else n_pass++;
    step();
    #1;
    n_chk++;
    if ({halted, pc_we, halted_n, pc_we_n, pc_sel_n} !== 6'b10_11_00)
      $display("FAIL trap_enter: got %b want 101100", {halted, pc_we, halted_n, pc_we_n, pc_sel_n});
    else n_pass++;
    step();
    #1;
    n_chk++;
    if ({halted_n, imem_req_n} !== 2'b01)
      $display("FAIL trap_resume: got %b want 01", {halted_n, imem_req_n});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      imem_ack = (i == 1);  // fetch acks are ignored while parked
      #1;
      n_chk++;
      if ({halted, pc_we, imem_req, ir_we} !== 4'b1000)
        $display("FAIL trap_park[%0d]: got %b want 1000", i, {halted, pc_we, imem_req, ir_we});
      else n_pass++;
      step();
    end
    imem_ack = 1'b0;
    // Reserved load funct3 also traps.
    apply_reset();
    fetch_instr(32'h0040_B183);
    step();
    #1;
    n_chk++;
    if ({halted, dmem_req} !== 2'b10) $display("FAIL trap_bad_load: got %b want 10", {halted, dmem_req});
    else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    fetch_instr(32'h0040_A183);
    step();
    step();
    #1;
    n_chk++;
    if (dmem_req !== 1'b1) $display("FAIL rmem_wait: got %b want 1", dmem_req);
    else n_pass++;
    rst = 1'b1;
    step();
    n_chk++;
    if ({dmem_req, imem_req} !== 2'b00) $display("FAIL rmem_dropped: got %b want 00", {dmem_req, imem_req});
    else n_pass++;
    rst = 1'b0;
    dmem_ack = 1'b1;  // late ack after reset is ignored
    #1;
    n_chk++;
    if ({imem_req, dmem_req} !== 2'b10) $display("FAIL rmem_release: got %b want 10", {imem_req, dmem_req});
    else n_pass++;
    step();
    dmem_ack = 1'b0;
    #1;
    n_chk++;
    if ({imem_req, dmem_req, rf_we} !== 3'b100)
      $display("FAIL rmem_still_fetch: got %b want 100", {imem_req, dmem_req, rf_we});
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_branch();
    test_load_delayed();
    test_store();
    test_jumps();
    test_trap();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
